// File: rtl/stat_display.sv
// stat_display: selects one instruction-statistics counter, converts it to
// four BCD digits with a sequential double-dabble, and scans the result onto
// a 4-digit active-low multiplexed 7-segment display.
// Optional macro STAT_DISPLAY_BLANK_EN enables leading-zero blanking.
module stat_display #(
   parameter int WIDTH       = 11,
   parameter int SCAN_DIV    = 50000,
   parameter int REFRESH_DIV = 5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i,
   input  logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] cnt_clk,
   input  logic [1:0]       sel,
   output logic [15:0]      bcd,
   output logic             busy,
   output logic             done,
   output logic [3:0]       an,
   output logic [7:0]       seg
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int RW = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [1:0]       sel_q;
   logic             pending;
   logic [RW-1:0]    ref_cnt;
   logic             ref_tick;
   logic             start;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] bin;
   logic [15:0]      scratch;
   logic [15:0]      adj;
   logic [CW-1:0]    shift_cnt;
   logic [SW-1:0]    scan_cnt;
   logic [1:0]       index;
   logic [3:0]       digit;
   logic             blank;

   assign ref_tick = (ref_cnt == RW'(REFRESH_DIV - 1));

   // Active-low 7-segment pattern, dp off; out-of-range nibbles go dark.
   function automatic logic [7:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 8'hC0;
         4'd1:    decode = 8'hF9;
         4'd2:    decode = 8'hA4;
         4'd3:    decode = 8'hB0;
         4'd4:    decode = 8'h99;
         4'd5:    decode = 8'h92;
         4'd6:    decode = 8'h82;
         4'd7:    decode = 8'hF8;
         4'd8:    decode = 8'h80;
         4'd9:    decode = 8'h90;
         default: decode = 8'hFF;
      endcase
   endfunction

   // Source counter mux, sampled only when a conversion is loaded.
   always_comb begin
      case (sel)
         2'd0:    src = i;
         2'd1:    src = r;
         2'd2:    src = j;
         default: src = cnt_clk;
      endcase
   end

   // Double-dabble correction: add 3 to every nibble that is 5 or more.
   always_comb begin
      adj = scratch;
      for (int k = 0; k < 4; k++)
         if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
   end

   // Conversion FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Conversion FSM next-state logic.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      case (state)
         IDLE:  if (pending) begin
                   start    = 1'b1;
                   state_nx = SHIFT;
                end
         SHIFT: if (shift_cnt == CW'(WIDTH - 1)) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request tracking: source changes and refresh ticks merge into one pending flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q   <= 2'd0;
         pending <= 1'b1;
         ref_cnt <= '0;
      end else begin
         sel_q   <= sel;
         ref_cnt <= ref_tick ? '0 : ref_cnt + RW'(1);
         pending <= (pending & ~start) | (sel != sel_q) | ref_tick;
      end
   end

   // Conversion datapath: load, WIDTH shift steps, then publish the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         bin       <= '0;
         scratch   <= '0;
         shift_cnt <= '0;
         bcd       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
                     bin       <= src;
                     scratch   <= '0;
                     shift_cnt <= '0;
                     busy      <= 1'b1;
                  end
            SHIFT: begin
               scratch   <= {adj[14:0], bin[WIDTH-1]};
               bin       <= bin << 1;
               shift_cnt <= shift_cnt + CW'(1);
            end
            DONE: begin
               bcd  <= scratch;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign digit = bcd[{index, 2'b00} +: 4];

`ifdef STAT_DISPLAY_BLANK_EN
   // A digit is blanked when it and every more significant digit are zero.
   assign blank = (index != 2'd0) && ((bcd >> {index, 2'b00}) == 16'd0);
`else
   assign blank = 1'b0;
`endif

   // Digit scan: advance the lit digit every SCAN_DIV cycles; register an/seg together.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         index    <= 2'd0;
         an       <= 4'b1111;
         seg      <= 8'hFF;
      end else begin
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            index    <= index + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         an  <= blank ? 4'b1111 : ~(4'b0001 << index);
         seg <= blank ? 8'hFF : decode(digit);
      end
   end

endmodule

// File: tb/tb_stat_display.sv
// tb_stat_display: directed vector table, scan/blanking checks, multi-cycle
// corner sequences and randomized values checked against an arithmetic model.
module tb_stat_display;

   localparam int WIDTH = 11;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] i = '0, r = '0, j = '0, cnt_clk = '0;
   logic [1:0]  sel = 2'd0;
   logic [15:0] bcd;
   logic        busy, done;
   logic [3:0]  an;
   logic [7:0]  seg;

   int checks = 0;
   int errors = 0;

   stat_display #(.WIDTH(WIDTH), .SCAN_DIV(4), .REFRESH_DIV(64)) dut (
      .clk(clk), .reset(reset), .i(i), .r(r), .j(j), .cnt_clk(cnt_clk),
      .sel(sel), .bcd(bcd), .busy(busy), .done(done), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  s;
      logic [10:0] vi, vr, vj, vc;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[6];
   logic [7:0] seg_tab[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Decimal digits by plain arithmetic.
   function automatic logic [15:0] to_bcd(input int v);
      return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction

   function automatic int pick(input int s, input int a, input int b, input int c, input int d);
      case (s)
         0: return a;
         1: return b;
         2: return c;
         default: return d;
      endcase
   endfunction

   task automatic wait_done(input string name, input int maxc);
      bit ok;
      ok = 0;
      for (int n = 0; n < maxc; n++) begin
         tick();
         if (done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic set_in(input int s, input int a, input int b, input int c, input int d);
      sel = 2'(s); i = 11'(a); r = 11'(b); j = 11'(c); cnt_clk = 11'(d);
   endtask

   initial begin
      int lat, ndone, nslot0, prev;
      bit synced;

      vecs[0] = '{2'd0, 11'd1234, 11'd0,   11'd0,   11'd0,    16'h1234};
      vecs[1] = '{2'd3, 11'd0,    11'd0,   11'd0,   11'd2047, 16'h2047};
      vecs[2] = '{2'd3, 11'd0,    11'd0,   11'd0,   11'd5,    16'h0005};
      vecs[3] = '{2'd1, 11'd0,    11'd7,   11'd0,   11'd0,    16'h0007};
      vecs[4] = '{2'd2, 11'd0,    11'd0,   11'd999, 11'd0,    16'h0999};
      vecs[5] = '{2'd0, 11'd0,    11'd0,   11'd0,   11'd0,    16'h0000};
      seg_tab[0] = 8'h99; seg_tab[1] = 8'hB0; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hF9;

      // Reset state
      set_in(0, 1234, 0, 0, 0);
      tick(); tick();
      check("rst_bcd", bcd, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 8'hFF);

      // First conversion: start on first edge after release, done 12 edges later
      reset = 1'b0;
      tick();
      check("t1_busy_rise", busy, 1);
      lat = 0; ndone = 0;
      for (int n = 2; n <= 20; n++) begin
         tick();
         if (done) begin
            ndone++;
            if (lat == 0) lat = n - 1;
         end
      end
      check("t1_latency", lat, 12);
      check("t1_done_count", ndone, 1);
      check("t1_bcd", bcd, 16'h1234);
      check("t1_busy_after", busy, 0);

      // Scan of 1234: find start of slot 0, then walk four slots of 4 cycles
      synced = 0;
      prev = an;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (an == 4'b1110 && prev != 4'b1110) begin
            synced = 1;
            break;
         end
         prev = an;
      end
      check("t3_sync", synced, 1);
      for (int c = 0; c < 17; c++) begin
         check($sformatf("t3_an_c%0d", c), an, ~(4'b0001 << ((c / 4) % 4)) & 4'hF);
         check($sformatf("t3_seg_c%0d", c), seg, seg_tab[(c / 4) % 4]);
         tick();
      end

      // Vector table: the second done after a change surely reflects new inputs
      foreach (vecs[k]) begin
         set_in(vecs[k].s, vecs[k].vi, vecs[k].vr, vecs[k].vj, vecs[k].vc);
         wait_done($sformatf("vec%0d_a", k), 200);
         wait_done($sformatf("vec%0d_b", k), 200);
         check($sformatf("vec%0d_bcd", k), bcd, vecs[k].exp);
         tick();
         check($sformatf("vec%0d_done_pulse", k), done, 0);
      end

      // Value 0 on display: slot 0 shows "0"; other slots depend on blanking
      nslot0 = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (an == 4'b1110) begin
            nslot0++;
            check("t6_seg_slot0", seg, 8'hC0);
         end else begin
`ifdef STAT_DISPLAY_BLANK_EN
            check("t6_an_blank", an, 4'hF);
            check("t6_seg_blank", seg, 8'hFF);
`else
            check("t6_an_onecold", (an == 4'b1101 || an == 4'b1011 || an == 4'b0111) ? 1 : 0, 1);
            check("t6_seg_zero", seg, 8'hC0);
`endif
         end
      end
      check("t6_slot0_cycles", nslot0, 4);

      // Source change mid-SHIFT: both conversions complete in order
      wait_done("t4_sync", 200);
      set_in(1, 100, 7, 0, 0);
      tick(); tick(); tick();
      check("t4_busy", busy, 1);
      tick(); tick(); tick();
      set_in(0, 100, 7, 0, 0);
      wait_done("t4_first", 30);
      check("t4_first_bcd", bcd, 16'h0007);
      wait_done("t4_second", 30);
      check("t4_second_bcd", bcd, 16'h0100);

      // Randomized values checked against the arithmetic model
      for (int k = 0; k < 12; k++) begin
         int s, a, b, c, d;
         s = int'($urandom_range(0, 3));
         a = int'($urandom_range(0, 2047)); b = int'($urandom_range(0, 2047));
         c = int'($urandom_range(0, 2047)); d = int'($urandom_range(0, 2047));
         set_in(s, a, b, c, d);
         wait_done($sformatf("rnd%0d_a", k), 200);
         wait_done($sformatf("rnd%0d_b", k), 200);
         check($sformatf("rnd%0d_bcd", k), bcd, to_bcd(pick(s, a, b, c, d)));
      end

      // Reset during SHIFT aborts; a fresh conversion follows release
      wait_done("t5_sync", 200);
      set_in(2, 0, 0, 321, 0);
      tick(); tick(); tick(); tick();
      check("t5_busy", busy, 1);
      reset = 1'b1;
      tick();
      check("t5_bcd", bcd, 0);
      check("t5_busy_rst", busy, 0);
      check("t5_an", an, 4'hF);
      check("t5_seg", seg, 8'hFF);
      reset = 1'b0;
      tick();
      check("t5_restart", busy, 1);
      wait_done("t5_conv", 20);
      check("t5_bcd_after", bcd, 16'h0321);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
